// File: rtl/alu_pkg.sv
// Opcode map, FSM state encoding and opcode helper shared by the multi-cycle ALU and its multiplier.
// Pure definitions: no latency, no flow control.
package alu_pkg;

  localparam int OPW = 4;

  localparam logic [OPW-1:0] ALU_ADD = 4'd0;
  localparam logic [OPW-1:0] ALU_SUB = 4'd1;
  localparam logic [OPW-1:0] ALU_SLL = 4'd2;
  localparam logic [OPW-1:0] ALU_SRL = 4'd3;
  localparam logic [OPW-1:0] ALU_SRA = 4'd4;
  localparam logic [OPW-1:0] ALU_AND = 4'd5;
  localparam logic [OPW-1:0] ALU_OR  = 4'd6;
  localparam logic [OPW-1:0] ALU_XOR = 4'd7;
  localparam logic [OPW-1:0] ALU_MUL = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic op_is_valid(input logic [OPW-1:0] op);
    return (op <= ALU_MUL);
  endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Unsigned W x W shift-add multiplier, one multiplier bit per cycle LSB first; o_done marks the W-th step.
// o_product is the combinational post-step value, so it is final in the o_done cycle; no backpressure.
module shift_add_multiplier #(
  parameter  int W   = 16,
  localparam int SHW = $clog2(W)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*W-1:0] o_product
);

  localparam logic [SHW-1:0] LAST_STEP = SHW'(W - 1);

  logic [2*W-1:0] r_mcand;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_mplier;
  logic [SHW-1:0] r_cnt;
  logic           r_busy;
  logic [2*W-1:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{W{1'b0}}, i_a};
      r_acc    <= '0;
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == LAST_STEP) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_cnt == LAST_STEP);
  assign o_product = w_acc_nxt;

endmodule

// File: rtl/multicycle_alu.sv
// W-bit ALU with registered result/flags: 1-cycle latency for simple ops, W+1 for MUL, accept-to-valid.
// Accepts only in IDLE; the result is held in DONE until input_Ready, so one op in flight at a time.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter  int W   = 16,
  localparam int SHW = $clog2(W)
) (
  input  logic           input_CLK,
  input  logic           input_Reset,
  input  logic           input_Valid,
  output logic           output_Ready,
  input  logic [W-1:0]   input_A,
  input  logic [W-1:0]   input_B,
  input  logic [OPW-1:0] input_ALUOp,
  output logic           output_Valid,
  input  logic           input_Ready,
  output logic [W-1:0]   output_ALU,
  output logic           output_Zero,
  output logic           output_negative,
  output logic           output_Carry,
  output logic           output_Overflow,
  output logic           output_Error
);

  state_t         r_state;
  logic           r_valid;
  logic [W-1:0]   r_alu;
  logic           r_zero;
  logic           r_neg;
  logic           r_carry;
  logic           r_ovf;
  logic           r_err;

  logic           w_accept;
  logic           w_mul_start;
  logic           w_mul_busy;
  logic           w_mul_done;
  logic [2*W-1:0] w_product;

  logic [W:0]     w_sum;
  logic [W:0]     w_diff;
  logic [W-1:0]   w_sra;
  logic [SHW-1:0] w_sh;
  logic           w_sh_big;
  logic [W-1:0]   w_res;
  logic           w_carry;
  logic           w_ovf;
  logic           w_err;

  assign output_Ready = (r_state == S_IDLE);
  assign w_accept     = input_Valid && output_Ready;
  assign w_mul_start  = w_accept && (input_ALUOp == ALU_MUL) && !input_Reset;

  shift_add_multiplier #(.W(W)) u_mul (
    .i_clk     (input_CLK),
    .i_rst     (input_Reset),
    .i_start   (w_mul_start),
    .i_a       (input_A),
    .i_b       (input_B),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  // The whole of B is the shift amount: any bit at or above SHW means a shift of W or more.
  assign w_sh     = input_B[SHW-1:0];
  assign w_sh_big = |input_B[W-1:SHW];
  assign w_sum    = {1'b0, input_A} + {1'b0, input_B};
  assign w_diff   = {1'b0, input_A} - {1'b0, input_B};
  assign w_sra    = $signed(input_A) >>> w_sh;
  assign w_err    = !op_is_valid(input_ALUOp);

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (input_ALUOp)
      ALU_ADD: begin
        w_res   = w_sum[W-1:0];
        w_carry = w_sum[W];
        w_ovf   = (input_A[W-1] == input_B[W-1]) && (w_sum[W-1] != input_A[W-1]);
      end
      ALU_SUB: begin
        w_res   = w_diff[W-1:0];
        w_carry = w_diff[W];
        w_ovf   = (input_A[W-1] != input_B[W-1]) && (w_diff[W-1] != input_A[W-1]);
      end
      ALU_SLL: w_res = w_sh_big ? '0 : (input_A << w_sh);
      ALU_SRL: w_res = w_sh_big ? '0 : (input_A >> w_sh);
      ALU_SRA: w_res = w_sh_big ? {W{input_A[W-1]}} : w_sra;
      ALU_AND: w_res = input_A & input_B;
      ALU_OR:  w_res = input_A | input_B;
      ALU_XOR: w_res = input_A ^ input_B;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge input_CLK) begin
    if (input_Reset) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_alu   <= '0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (input_ALUOp == ALU_MUL) begin
              r_state <= S_MUL;
            end else begin
              r_state <= S_DONE;
              r_valid <= 1'b1;
              r_alu   <= w_res;
              r_zero  <= (w_res == '0);
              r_neg   <= w_res[W-1];
              r_carry <= w_carry;
              r_ovf   <= w_ovf;
              r_err   <= w_err;
            end
          end
        end
        S_MUL: begin
          // Flags are taken only from the completed product, never from partial sums.
          if (w_mul_done) begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
            r_alu   <= w_product[W-1:0];
            r_zero  <= (w_product[W-1:0] == '0);
            r_neg   <= w_product[W-1];
            r_carry <= |w_product[2*W-1:W];
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
          end else if (!w_mul_busy) begin
            r_state <= S_IDLE;
          end
        end
        S_DONE: begin
          if (input_Ready) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign output_Valid    = r_valid;
  assign output_ALU      = r_alu;
  assign output_Zero     = r_zero;
  assign output_negative = r_neg;
  assign output_Carry    = r_carry;
  assign output_Overflow = r_ovf;
  assign output_Error    = r_err;

endmodule

// File: tb/tb_multicycle_alu.sv
// Table-driven bench for multicycle_alu (W=16) with a scoreboard queue and hand-written reset/backpressure sequences.
module tb_multicycle_alu;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_vld;
  logic         out_rdy;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         out_vld;
  logic         in_rdy;
  logic [W-1:0] alu;
  logic         zero;
  logic         neg;
  logic         carry;
  logic         ovf;
  logic         err;

  multicycle_alu #(.W(W)) dut (
    .input_CLK       (clk),
    .input_Reset     (rst),
    .input_Valid     (in_vld),
    .output_Ready    (out_rdy),
    .input_A         (a),
    .input_B         (b),
    .input_ALUOp     (op),
    .output_Valid    (out_vld),
    .input_Ready     (in_rdy),
    .output_ALU      (alu),
    .output_Zero     (zero),
    .output_negative (neg),
    .output_Carry    (carry),
    .output_Overflow (ovf),
    .output_Error    (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] alu;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
    logic         e;
    int           lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] op_, input logic [W-1:0] a_, input logic [W-1:0] b_,
                     input logic [W-1:0] r_, input logic z_, input logic n_, input logic c_,
                     input logic v_, input logic e_);
    vec_t t;
    t.op = op_; t.a = a_; t.b = b_; t.alu = r_;
    t.z = z_; t.n = n_; t.c = c_; t.v = v_; t.e = e_;
    t.lat = (op_ == 4'd8) ? W + 1 : 1;
    tbl.push_back(t);
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic issue(input vec_t v);
    int  n = 0;
    sb_t s;
    while (!out_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue ready", 32'(out_rdy), 32'd1);
    in_vld = 1'b1;
    a = v.a; b = v.b; op = v.op;
    s.v = v;
    s.acc = cyc;
    sb_q.push_back(s);
    @(negedge clk);
    in_vld = 1'b0;
    a  = W'($urandom);
    b  = W'($urandom);
    op = 4'($urandom);
  endtask

  task automatic wait_result(input string tag, input int hold);
    int  n = 0;
    sb_t s;
    while (!out_vld && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " valid"}, 32'(out_vld), 32'd1);
    chk({tag, " sb depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() == 0) return;
    s = sb_q.pop_front();
    chk({tag, " latency"}, 32'(cyc - s.acc), 32'(s.v.lat));
    chk({tag, " alu"},   32'(alu),   32'(s.v.alu));
    chk({tag, " zero"},  32'(zero),  32'(s.v.z));
    chk({tag, " neg"},   32'(neg),   32'(s.v.n));
    chk({tag, " carry"}, 32'(carry), 32'(s.v.c));
    chk({tag, " ovf"},   32'(ovf),   32'(s.v.v));
    chk({tag, " err"},   32'(err),   32'(s.v.e));
    for (int i = 0; i < hold; i++) begin
      in_vld = 1'b1; op = 4'd0; a = 16'h0001; b = 16'h0001;
      @(negedge clk);
      chk({tag, " hold valid"}, 32'(out_vld), 32'd1);
      chk({tag, " hold alu"},   32'(alu),     32'(s.v.alu));
      chk({tag, " hold ready"}, 32'(out_rdy), 32'd0);
    end
    in_vld = 1'b0;
    in_rdy = 1'b1;
    @(negedge clk);
    chk({tag, " valid drop"}, 32'(out_vld), 32'd0);
    chk({tag, " ready back"}, 32'(out_rdy), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   seen;

    //   op     A         B         ALU      Z  N  C  V  E
    add(4'd0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1, 0);
    add(4'd1, 16'h0003, 16'h0005, 16'hFFFE, 0, 1, 1, 0, 0);
    add(4'd1, 16'h1234, 16'h1234, 16'h0000, 1, 0, 0, 0, 0);
    add(4'd4, 16'h8000, 16'h0004, 16'hF800, 0, 1, 0, 0, 0);
    add(4'd4, 16'h8000, 16'h0014, 16'hFFFF, 0, 1, 0, 0, 0);
    add(4'd2, 16'h0001, 16'h0010, 16'h0000, 1, 0, 0, 0, 0);
    add(4'd8, 16'h0100, 16'h0100, 16'h0000, 1, 0, 1, 0, 0);
    add(4'd8, 16'h00FF, 16'h0003, 16'h02FD, 0, 0, 0, 0, 0);
    add(4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 0, 0);
    add(4'd1, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 0, 1, 0);
    add(4'd3, 16'h8000, 16'h000F, 16'h0001, 0, 0, 0, 0, 0);
    add(4'd3, 16'hF0F0, 16'h0000, 16'hF0F0, 0, 1, 0, 0, 0);
    add(4'd2, 16'h00FF, 16'h0004, 16'h0FF0, 0, 0, 0, 0, 0);
    add(4'd5, 16'hF0F0, 16'h3C3C, 16'h3030, 0, 0, 0, 0, 0);
    add(4'd6, 16'hF0F0, 16'h0F00, 16'hFFF0, 0, 1, 0, 0, 0);
    add(4'd7, 16'hAAAA, 16'hAAAA, 16'h0000, 1, 0, 0, 0, 0);
    add(4'hF, 16'h1234, 16'h5678, 16'h0000, 1, 0, 0, 0, 1);
    add(4'd8, 16'hFFFF, 16'hFFFF, 16'h0001, 0, 0, 1, 0, 0);
    add(4'd4, 16'h7000, 16'h0010, 16'h0000, 1, 0, 0, 0, 0);
    add(4'd4, 16'h4000, 16'h0001, 16'h2000, 0, 0, 0, 0, 0);
    add(4'd2, 16'h0001, 16'hFFFF, 16'h0000, 1, 0, 0, 0, 0);
    add(4'd8, 16'h1234, 16'h0000, 16'h0000, 1, 0, 0, 0, 0);

    rst = 1'b1; in_vld = 1'b0; in_rdy = 1'b1; a = '0; b = '0; op = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset ready", 32'(out_rdy), 32'd1);
    chk("reset valid", 32'(out_vld), 32'd0);
    chk("reset alu",   32'(alu),     32'd0);
    chk("reset flags", 32'({zero, neg, carry, ovf, err}), 32'd0);

    foreach (tbl[i]) begin
      issue(tbl[i]);
      wait_result($sformatf("vec%0d", i), 0);
    end

    // Backpressure: result held for 5 cycles while a competing request is offered.
    in_rdy = 1'b0;
    v.op = 4'd7; v.a = 16'h1234; v.b = 16'h00FF; v.alu = 16'h12CB;
    v.z = 0; v.n = 0; v.c = 0; v.v = 0; v.e = 0; v.lat = 1;
    issue(v);
    wait_result("bp", 5);
    repeat (3) @(negedge clk);
    chk("bp request ignored", 32'(out_vld), 32'd0);

    // Reset in the 8th cycle of a multiply abandons it.
    op = 4'd8; a = 16'h00FF; b = 16'h0003; in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    repeat (7) @(negedge clk);
    chk("mulrst busy", 32'(out_rdy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mulrst ready", 32'(out_rdy), 32'd1);
    chk("mulrst valid", 32'(out_vld), 32'd0);
    chk("mulrst alu",   32'(alu),     32'd0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_vld) seen++;
    end
    chk("mulrst no pulse", 32'(seen), 32'd0);

    v.op = 4'hA; v.a = 16'h1111; v.b = 16'h2222; v.alu = 16'h0000;
    v.z = 1; v.n = 0; v.c = 0; v.v = 0; v.e = 1; v.lat = 1;
    issue(v);
    wait_result("op_a", 0);
    v.op = 4'd8; v.a = 16'h0003; v.b = 16'h0005; v.alu = 16'h000F;
    v.z = 0; v.n = 0; v.c = 0; v.v = 0; v.e = 0; v.lat = W + 1;
    issue(v);
    wait_result("mul after rst", 0);

    // Reset and request in the same cycle: reset wins.
    rst = 1'b1; in_vld = 1'b1; op = 4'd0; a = 16'h0001; b = 16'h0001;
    @(negedge clk);
    rst = 1'b0; in_vld = 1'b0;
    @(negedge clk);
    chk("rst+acc valid", 32'(out_vld), 32'd0);
    chk("rst+acc ready", 32'(out_rdy), 32'd1);

    // Reset while holding a result in DONE.
    in_rdy = 1'b0;
    v.op = 4'd0; v.a = 16'h0002; v.b = 16'h0003; v.alu = 16'h0005;
    v.z = 0; v.n = 0; v.c = 0; v.v = 0; v.e = 0; v.lat = 1;
    issue(v);
    chk("rstdone valid", 32'(out_vld), 32'd1);
    chk("rstdone alu",   32'(alu),     32'h5);
    void'(sb_q.pop_front());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_rdy = 1'b1;
    chk("rstdone drop",  32'(out_vld), 32'd0);
    chk("rstdone ready", 32'(out_rdy), 32'd1);
    chk("rstdone clear", 32'(alu),     32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
